// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The controller is the master; the datapath is the slave.
interface multicycle_controller_if;
    logic [6:0] op_code;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       adr_src;
    logic       mem_write;
    logic       IR_write;
    logic       reg_write;
    logic       PC_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal_instr;

    modport master (
        input  op_code, funct3, funct7, Zero,
        output adr_src, mem_write, IR_write, reg_write, PC_write,
        output result_src, alu_src_a, alu_src_b, imm_src,
        output alu_control, illegal_instr
    );

    modport slave (
        output op_code, funct3, funct7, Zero,
        input  adr_src, mem_write, IR_write, reg_write, PC_write,
        input  result_src, alu_src_a, alu_src_b, imm_src,
        input  alu_control, illegal_instr
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch,
// decode, execute, memory and writeback, driving all datapath controls.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    state_t     state_q;
    state_t     state_d;
    state_t     dec_next;
    logic       dec_bad;
    logic [2:0] alu_fn;

    always_ff @(posedge clk) begin
        if (reset) state_q <= state_t'(RESET_STATE);
        else       state_q <= state_d;
    end

    // Decode target and legality check, evaluated while in DECODE
    always_comb begin
        dec_next = FETCH;
        dec_bad  = 1'b0;
        case (bus.op_code)
            OP_LOAD, OP_STORE: dec_next = MEMADR;
            OP_R: begin
                dec_next = EXECUTER;
                dec_bad  = (bus.funct3 == 3'b011)
                        || ((bus.funct7 != 7'b0000000) && (bus.funct7 != 7'b0100000))
                        || ((bus.funct3 == 3'b101) && bus.funct7[5]);
            end
            OP_I: begin
                dec_next = EXECUTEI;
                dec_bad  = (bus.funct3 == 3'b011)
                        || ((bus.funct3 == 3'b101) && bus.funct7[5]);
            end
            OP_B: begin
                dec_next = BRANCH;
                dec_bad  = (bus.funct3[2:1] != 2'b00);
            end
            OP_JAL:  dec_next = JAL;
            default: dec_bad  = 1'b1;
        endcase
    end

    always_comb begin
        alu_fn = ALU_ADD;
        case (bus.funct3)
            3'b000: alu_fn = ((state_q == EXECUTER) && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: alu_fn = ALU_SLL;
            3'b010: alu_fn = ALU_SLT;
            3'b100: alu_fn = ALU_XOR;
            3'b101: alu_fn = ALU_SRL;
            3'b110: alu_fn = ALU_OR;
            3'b111: alu_fn = ALU_AND;
            default: alu_fn = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d           = FETCH;
        bus.adr_src       = 1'b0;
        bus.mem_write     = 1'b0;
        bus.IR_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.PC_write      = 1'b0;
        bus.result_src    = 2'b00;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.imm_src       = 2'b00;
        bus.alu_control   = ALU_ADD;
        bus.illegal_instr = 1'b0;
        case (state_q)
            FETCH: begin
                bus.IR_write   = 1'b1;
                bus.PC_write   = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                state_d        = DECODE;
            end
            DECODE: begin
                bus.alu_src_a     = 2'b01;
                bus.alu_src_b     = 2'b01;
                bus.imm_src       = 2'b10;
                bus.illegal_instr = dec_bad;
                state_d           = dec_bad ? FETCH : dec_next;
            end
            MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = (bus.op_code == OP_STORE) ? 2'b01 : 2'b00;
                state_d       = (bus.op_code == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.adr_src = 1'b1;
                state_d     = MEMWB;
            end
            MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            EXECUTER: begin
                bus.alu_src_a   = 2'b10;
                bus.alu_control = alu_fn;
                state_d         = ALUWB;
            end
            EXECUTEI: begin
                bus.alu_src_a   = 2'b10;
                bus.alu_src_b   = 2'b01;
                bus.alu_control = alu_fn;
                state_d         = ALUWB;
            end
            ALUWB: bus.reg_write = 1'b1;
            BRANCH: begin
                bus.alu_src_a   = 2'b10;
                bus.alu_control = ALU_SUB;
                bus.PC_write    = (bus.funct3 == 3'b000) ?  bus.Zero :
                                  (bus.funct3 == 3'b001) ? !bus.Zero : 1'b0;
            end
            JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.PC_write  = 1'b1;
                state_d       = ALUWB;
            end
            default: state_d = FETCH;
        endcase
        // Reset silences every control regardless of the current state
        if (reset) begin
            bus.adr_src       = 1'b0;
            bus.mem_write     = 1'b0;
            bus.IR_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.PC_write      = 1'b0;
            bus.result_src    = 2'b00;
            bus.alu_src_a     = 2'b00;
            bus.alu_src_b     = 2'b00;
            bus.imm_src       = 2'b00;
            bus.alu_control   = ALU_ADD;
            bus.illegal_instr = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-cycle control words compared against an
// instruction-level reference model of the controller.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    multicycle_controller_if bus ();

    multicycle_controller #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {bus.adr_src, bus.mem_write, bus.IR_write, bus.reg_write,
                  bus.PC_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                  bus.imm_src, bus.alu_control, bus.illegal_instr};

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3;
    localparam int K_BR = 4, K_JAL = 5, K_ILL = 6;

    function automatic logic [16:0] mk(
        input logic adr, input logic mw, input logic irw, input logic rw,
        input logic pcw, input logic [1:0] rs, input logic [1:0] a,
        input logic [1:0] b, input logic [1:0] imm, input logic [2:0] alu,
        input logic ill);
        return {adr, mw, irw, rw, pcw, rs, a, b, imm, alu, ill};
    endfunction

    function automatic int kind_of(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7);
        case (op)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: begin
                if (f3 == 3'd3) return K_ILL;
                if (f7 != 7'h00 && f7 != 7'h20) return K_ILL;
                if (f3 == 3'd5 && f7[5]) return K_ILL;
                return K_R;
            end
            7'b0010011: begin
                if (f3 == 3'd3) return K_ILL;
                if (f3 == 3'd5 && f7[5]) return K_ILL;
                return K_I;
            end
            7'b1100011: return (f3 <= 3'd1) ? K_BR : K_ILL;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic int lat(input int k);
        case (k)
            K_LW:    return 5;
            K_SW:    return 4;
            K_R:     return 4;
            K_I:     return 4;
            K_BR:    return 3;
            K_JAL:   return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3,
                                          input logic [6:0] f7, input logic is_r);
        case (f3)
            3'd0:    return (is_r && f7[5]) ? 3'b001 : 3'b000;
            3'd1:    return 3'b110;
            3'd2:    return 3'b101;
            3'd4:    return 3'b100;
            3'd5:    return 3'b111;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control word in cycle c (1 = FETCH) of an instruction
    function automatic logic [16:0] model(input int k, input int c,
        input logic [2:0] f3, input logic [6:0] f7, input logic z);
        logic br;
        if (c == 1) return mk(0,0,1,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0);
        if (c == 2) return mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,
                              k == K_ILL);
        br = (f3 == 3'd0) ? z : !z;
        case (k)
            K_LW: case (c)
                3:       return mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0);
                4:       return mk(1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
                default: return mk(0,0,0,1,0,2'b01,2'b00,2'b00,2'b00,3'b000,0);
            endcase
            K_SW: if (c == 3)
                     return mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0);
                  else
                     return mk(1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
            K_R: if (c == 3)
                     return mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,alu_of(f3,f7,1),0);
                 else
                     return mk(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
            K_I: if (c == 3)
                     return mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,alu_of(f3,f7,0),0);
                 else
                     return mk(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
            K_BR: return mk(0,0,0,0,br,2'b00,2'b10,2'b00,2'b00,3'b001,0);
            K_JAL: if (c == 3)
                     return mk(0,0,0,0,1,2'b00,2'b01,2'b10,2'b00,3'b000,0);
                   else
                     return mk(0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
            default: return '0;
        endcase
    endfunction

    // Runs one instruction from FETCH; zsel 0/1 fixes Zero, 2 randomises it
    task automatic run_instr(input string nm, input logic [6:0] op,
        input logic [2:0] f3, input logic [6:0] f7, input int zsel, input int ncyc);
        int k, n;
        logic [16:0] e;
        k = kind_of(op, f3, f7);
        n = (ncyc > 0 && ncyc < lat(k)) ? ncyc : lat(k);
        bus.op_code = op;
        bus.funct3  = f3;
        bus.funct7  = f7;
        for (int c = 1; c <= n; c++) begin
            bus.Zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            @(negedge clk);
            e = model(k, c, f3, f7, bus.Zero);
            nvec++;
            if (obs !== e) begin
                nerr++;
                $display("FAIL %s cyc%0d: got %h want %h", nm, c, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.op_code = 7'b0000011;
        bus.funct3 = 3'd0;
        bus.funct7 = 7'd0;
        bus.Zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            nvec++;
            if (obs !== 17'd0) begin
                nerr++;
                $display("FAIL reset_hold%0d: got %h want %h", i, obs, 17'd0);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_load();
        run_instr("lw", 7'b0000011, 3'd2, 7'd0, 2, 0);
    endtask

    task automatic test_rtype();
        run_instr("sub", 7'b0110011, 3'd0, 7'b0100000, 2, 0);
        run_instr("add", 7'b0110011, 3'd0, 7'b0000000, 2, 0);
        run_instr("addi_f7", 7'b0010011, 3'd0, 7'b0100000, 2, 0);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", 7'b1100011, 3'd0, 7'd0, 1, 0);
        run_instr("beq_z0", 7'b1100011, 3'd0, 7'd0, 0, 0);
        run_instr("bne_z0", 7'b1100011, 3'd1, 7'd0, 0, 0);
        run_instr("bne_z1", 7'b1100011, 3'd1, 7'd0, 1, 0);
    endtask

    task automatic test_store();
        run_instr("sw", 7'b0100011, 3'd2, 7'd0, 2, 0);
        run_instr("jal", 7'b1101111, 3'd0, 7'd0, 2, 0);
    endtask

    task automatic test_illegal();
        run_instr("lui", 7'b0110111, 3'd0, 7'd0, 2, 0);
        run_instr("srai", 7'b0010011, 3'd5, 7'b0100000, 2, 0);
        run_instr("sltu", 7'b0110011, 3'd3, 7'd0, 2, 0);
        run_instr("blt", 7'b1100011, 3'd4, 7'd0, 2, 0);
        run_instr("r_f7", 7'b0110011, 3'd0, 7'b0000001, 2, 0);
    endtask

    task automatic test_reset_midinstr();
        run_instr("lw_cut", 7'b0000011, 3'd2, 7'd0, 2, 3);
        reset = 1'b1;
        @(negedge clk);
        nvec++;
        if (obs !== 17'd0) begin
            nerr++;
            $display("FAIL reset_mid: got %h want %h", obs, 17'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr("after_reset", 7'b0110011, 3'd7, 7'd0, 2, 0);
    endtask

    task automatic test_random();
        logic [6:0] ops [8];
        logic [6:0] op, f7;
        logic [2:0] f3;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0110111, 7'b0000000};
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) op = 7'($urandom);
            f3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            run_instr("rand", op, f3, f7, 2, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.op_code = '0;
        bus.funct3 = '0;
        bus.funct7 = '0;
        bus.Zero = 1'b0;
        test_reset();
        test_load();
        test_rtype();
        test_branch();
        test_store();
        test_illegal();
        test_reset_midinstr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
